// File: rtl/eth_link_ctrl_pkg.sv
// Shared definitions for the Ethernet link bring-up controller: state
// encodings, default timing values and small state-decode helpers. The
// register file and software header generation read the same constants.
package eth_link_ctrl_pkg;

  // Default timing/retry values (all counts are in clk_i cycles, all >= 1).
  localparam int unsigned DEF_PLL_SETTLE_CYCLES    = 32'd1000;
  localparam int unsigned DEF_PCS_RESET_CYCLES     = 32'd64;
  localparam int unsigned DEF_AN_TIMEOUT_CYCLES    = 32'd1000000;
  localparam int unsigned DEF_MAX_RETRIES          = 32'd3;
  localparam int unsigned DEF_LINK_DEBOUNCE_CYCLES = 32'd16;

  // Width of the shared cycle timer.
  localparam int unsigned TIMER_W = 32'd32;

  // State encodings as seen on link_state_o.
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_PLL   = 3'd1;
  localparam logic [2:0] ST_PCS_RESET  = 3'd2;
  localparam logic [2:0] ST_WAIT_AN    = 3'd3;
  localparam logic [2:0] ST_RESTART_AN = 3'd4;
  localparam logic [2:0] ST_LINK_UP    = 3'd5;
  localparam logic [2:0] ST_FAILED     = 3'd6;

  // PCS/PMA is held in reset until the PLLs have settled and the pulse ends.
  function automatic logic holds_pcs_reset(input logic [2:0] state);
    logic r;
    case (state)
      ST_IDLE, ST_WAIT_PLL, ST_PCS_RESET: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // States in which losing either PLL lock sends us back to settling.
  function automatic logic watches_pll(input logic [2:0] state);
    logic r;
    case (state)
      ST_PCS_RESET, ST_WAIT_AN, ST_RESTART_AN, ST_LINK_UP: r = 1'b1;
      default:                                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/eth_link_timer.sv
// Shared cycle timer for the link controller. Clear wins over count enable;
// when neither is asserted the value holds.
module eth_link_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             count_en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_r;

  // Cycle counter: clear has priority over increment.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear_i) begin
      count_r <= {WIDTH{1'b0}};
    end else if (count_en_i) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/eth_link_ctrl.sv
// Ethernet link bring-up controller: waits for PLL lock to settle, pulses
// the PCS/PMA reset, supervises autonegotiation with bounded retries and
// watches the established link with a debounced drop detector.
module eth_link_ctrl
  import eth_link_ctrl_pkg::*;
#(
  parameter int unsigned PLL_SETTLE_CYCLES    = DEF_PLL_SETTLE_CYCLES,
  parameter int unsigned PCS_RESET_CYCLES     = DEF_PCS_RESET_CYCLES,
  parameter int unsigned AN_TIMEOUT_CYCLES    = DEF_AN_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES          = DEF_MAX_RETRIES,
  parameter int unsigned LINK_DEBOUNCE_CYCLES = DEF_LINK_DEBOUNCE_CYCLES
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        restart_i,
  input  logic [1:0]  eth_pll_lock_i,
  input  logic        eth_an_complete_i,
  input  logic [15:0] eth_status_vector_i,
  output logic        pcs_reset_o,
  output logic        an_restart_o,
  output logic        link_up_o,
  output logic [2:0]  link_state_o,
  output logic [3:0]  retry_count_o,
  output logic [15:0] link_drop_count_o,
  output logic        error_o
);

  // Terminal timer values; every count parameter is at least 1.
  localparam logic [TIMER_W-1:0] SETTLE_LAST_C   = TIMER_W'(PLL_SETTLE_CYCLES - 32'd1);
  localparam logic [TIMER_W-1:0] PCS_LAST_C      = TIMER_W'(PCS_RESET_CYCLES - 32'd1);
  localparam logic [TIMER_W-1:0] AN_LAST_C       = TIMER_W'(AN_TIMEOUT_CYCLES - 32'd1);
  localparam logic [TIMER_W-1:0] DEBOUNCE_LAST_C = TIMER_W'(LINK_DEBOUNCE_CYCLES - 32'd1);
  localparam logic [3:0]         MAX_RETRY_C     = 4'(MAX_RETRIES);

  logic [2:0]         state_r;
  logic [2:0]         next_state_s;
  logic [3:0]         retry_r;
  logic [3:0]         retry_next_s;
  logic [15:0]        drop_r;
  logic [15:0]        drop_next_s;
  logic               reenter_s;
  logic               timer_clear_s;
  logic               timer_inc_s;
  logic [TIMER_W-1:0] timer_s;
  logic               locks_ok_s;
  logic               link_ok_s;
  logic               pcs_reset_r;
  logic               an_restart_r;
  logic               link_up_r;
  logic               error_r;
  logic               status_unused_s;

  assign locks_ok_s      = &eth_pll_lock_i;
  assign link_ok_s       = eth_status_vector_i[0];
  // Only the link bit of the PCS status vector drives this controller.
  assign status_unused_s = ^eth_status_vector_i[15:1];

  eth_link_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (timer_clear_s),
    .count_en_i (timer_inc_s),
    .count_o    (timer_s)
  );

  // Next-state, retry and drop-count decisions, highest priority first.
  always_comb begin
    next_state_s = state_r;
    retry_next_s = retry_r;
    drop_next_s  = drop_r;
    reenter_s    = 1'b0;
    if (!enable_i) begin
      // A disabled controller starts the next bring-up with a fresh budget.
      next_state_s = ST_IDLE;
      retry_next_s = 4'd0;
    end else if (!locks_ok_s && watches_pll(state_r)) begin
      next_state_s = ST_WAIT_PLL;
    end else if (restart_i && (state_r != ST_IDLE)) begin
      // Restart while already settling counts as a fresh entry.
      next_state_s = ST_WAIT_PLL;
      retry_next_s = 4'd0;
      reenter_s    = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_state_s = ST_WAIT_PLL;
        end
        ST_WAIT_PLL: begin
          if (locks_ok_s && (timer_s == SETTLE_LAST_C)) begin
            next_state_s = ST_PCS_RESET;
          end else begin
            next_state_s = ST_WAIT_PLL;
          end
        end
        ST_PCS_RESET: begin
          if (timer_s == PCS_LAST_C) begin
            next_state_s = ST_WAIT_AN;
          end else begin
            next_state_s = ST_PCS_RESET;
          end
        end
        ST_WAIT_AN: begin
          // Completion beats a timeout landing on the same cycle.
          if (eth_an_complete_i && link_ok_s) begin
            next_state_s = ST_LINK_UP;
            retry_next_s = 4'd0;
          end else if (timer_s == AN_LAST_C) begin
            if (retry_r == MAX_RETRY_C) begin
              next_state_s = ST_FAILED;
            end else begin
              next_state_s = ST_RESTART_AN;
              retry_next_s = retry_r + 4'd1;
            end
          end else begin
            next_state_s = ST_WAIT_AN;
          end
        end
        ST_RESTART_AN: begin
          next_state_s = ST_WAIT_AN;
        end
        ST_LINK_UP: begin
          if (!link_ok_s && (timer_s == DEBOUNCE_LAST_C)) begin
            next_state_s = ST_RESTART_AN;
            if (drop_r != 16'hFFFF) begin
              drop_next_s = drop_r + 16'd1;
            end else begin
              drop_next_s = drop_r;
            end
          end else begin
            next_state_s = ST_LINK_UP;
          end
        end
        ST_FAILED: begin
          next_state_s = ST_FAILED;
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Timer control: clear on every entry; in WAIT_PLL it measures the lock
  // stable time and in LINK_UP the consecutive link-down time.
  always_comb begin
    timer_clear_s = 1'b0;
    timer_inc_s   = 1'b0;
    if ((next_state_s != state_r) || reenter_s) begin
      timer_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_WAIT_PLL: begin
          if (locks_ok_s) begin
            timer_inc_s = 1'b1;
          end else begin
            timer_clear_s = 1'b1;
          end
        end
        ST_LINK_UP: begin
          if (!link_ok_s) begin
            timer_inc_s = 1'b1;
          end else begin
            timer_clear_s = 1'b1;
          end
        end
        ST_PCS_RESET, ST_WAIT_AN, ST_RESTART_AN: begin
          timer_inc_s = 1'b1;
        end
        default: begin
          timer_inc_s = 1'b0;
        end
      endcase
    end
  end

  // State, retry and drop-count registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ST_IDLE;
      retry_r <= 4'd0;
      drop_r  <= 16'd0;
    end else begin
      state_r <= next_state_s;
      retry_r <= retry_next_s;
      drop_r  <= drop_next_s;
    end
  end

  // Output flags decoded from the next state so they line up with state_r.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pcs_reset_r  <= 1'b1;
      an_restart_r <= 1'b0;
      link_up_r    <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      pcs_reset_r  <= holds_pcs_reset(next_state_s);
      an_restart_r <= (next_state_s == ST_RESTART_AN);
      link_up_r    <= (next_state_s == ST_LINK_UP);
      error_r      <= (next_state_s == ST_FAILED);
    end
  end

  assign pcs_reset_o       = pcs_reset_r;
  assign an_restart_o      = an_restart_r;
  assign link_up_o         = link_up_r;
  assign error_o           = error_r;
  assign link_state_o      = state_r;
  assign retry_count_o     = retry_r;
  assign link_drop_count_o = drop_r;

endmodule

// File: tb/tb_eth_link_ctrl.sv
// Self-checking bench for eth_link_ctrl with short timing parameters.
// Expected state visits are queued as stimulus is applied; a negedge monitor
// pops one entry per observed state change and checks the output decode.
module tb_eth_link_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic [1:0]  locks = 2'b00;
  logic        an = 1'b0;
  logic [15:0] status = 16'h0000;
  logic        pcs_reset;
  logic        an_restart;
  logic        link_up;
  logic [2:0]  link_state;
  logic [3:0]  retry;
  logic [15:0] drops;
  logic        error;

  int tests_run = 0;
  int tests_failed = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_prev = 3'd0;

  always #5 clk = ~clk;

  eth_link_ctrl #(
    .PLL_SETTLE_CYCLES    (8),
    .PCS_RESET_CYCLES     (4),
    .AN_TIMEOUT_CYCLES    (100),
    .MAX_RETRIES          (2),
    .LINK_DEBOUNCE_CYCLES (3)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .enable_i            (enable),
    .restart_i           (restart),
    .eth_pll_lock_i      (locks),
    .eth_an_complete_i   (an),
    .eth_status_vector_i (status),
    .pcs_reset_o         (pcs_reset),
    .an_restart_o        (an_restart),
    .link_up_o           (link_up),
    .link_state_o        (link_state),
    .retry_count_o       (retry),
    .link_drop_count_o   (drops),
    .error_o             (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while ((link_state !== st) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (link_state !== st) chk(tag, 32'(link_state), 32'(st));
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_state"},      32'(link_state), 32'd0);
    chk({pfx, "_pcs_reset"},  32'(pcs_reset),  32'd1);
    chk({pfx, "_an_restart"}, 32'(an_restart), 32'd0);
    chk({pfx, "_link_up"},    32'(link_up),    32'd0);
    chk({pfx, "_error"},      32'(error),      32'd0);
    chk({pfx, "_retry"},      32'(retry),      32'd0);
    chk({pfx, "_drops"},      32'(drops),      32'd0);
  endtask

  // Scoreboard monitor: each state change must match the next queued state.
  always @(negedge clk) begin
    if (link_state !== mon_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_state", 32'(link_state), 32'hFFFF_FFFF);
      end else begin
        chk("sb_state", 32'(link_state), 32'(exp_q.pop_front()));
      end
      chk("sb_pcs_reset",  32'(pcs_reset),  32'(link_state <= 3'd2));
      chk("sb_an_restart", 32'(an_restart), 32'(link_state == 3'd4));
      chk("sb_link_up",    32'(link_up),    32'(link_state == 3'd5));
      chk("sb_error",      32'(error),      32'(link_state == 3'd6));
      mon_prev <= link_state;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #60000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int n;
    int k;
    int pulses;
    int first_idx;
    int second_idx;

    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_disabled", 32'(link_state), 32'd0);

    // Nominal bring-up: 8 settle + 4 reset cycles, AN after 20 cycles.
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd3); exp_q.push_back(3'd5);
    locks = 2'b11;
    enable = 1'b1;
    wait_state(3'd1, 4, "to_wait_pll");
    n = 0;
    while (pcs_reset && (n < 50)) begin
      n++;
      @(negedge clk);
    end
    chk("pcs_reset_len", 32'(n), 32'd12);
    chk("in_wait_an", 32'(link_state), 32'd3);
    repeat (20) @(negedge clk);
    an = 1'b1;
    status = 16'h0001;
    wait_state(3'd5, 5, "to_link_up");
    chk("nominal_link_up", 32'(link_up), 32'd1);
    chk("nominal_retry", 32'(retry), 32'd0);

    // Two-cycle link glitch is ignored; upper status bits are don't-care.
    status = 16'hA5A4;
    repeat (2) @(negedge clk);
    status = 16'hA5A5;
    repeat (5) @(negedge clk);
    chk("glitch_state", 32'(link_state), 32'd5);
    chk("glitch_drops", 32'(drops), 32'd0);

    // Three-cycle drop: one restart pulse, drop counted, link returns.
    exp_q.push_back(3'd4); exp_q.push_back(3'd3); exp_q.push_back(3'd5);
    pulses = 0;
    status = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      if (an_restart) pulses++;
    end
    status = 16'h0001;
    repeat (6) begin
      @(negedge clk);
      if (an_restart) pulses++;
    end
    chk("drop_pulses", 32'(pulses), 32'd1);
    chk("drop_count", 32'(drops), 32'd1);
    chk("drop_relink", 32'(link_state), 32'd5);

    // Lock loss in LINK_UP, then a lock-0 glitch while settling, then AN
    // never completes: two restarts and FAILED.
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    exp_q.push_back(3'd4); exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    exp_q.push_back(3'd3); exp_q.push_back(3'd6);
    locks = 2'b10;
    an = 1'b0;
    status = 16'h0000;
    @(negedge clk);
    chk("lockloss_state", 32'(link_state), 32'd1);
    chk("lockloss_link_up", 32'(link_up), 32'd0);
    locks = 2'b11;
    repeat (5) @(negedge clk);
    locks = 2'b10;
    @(negedge clk);
    locks = 2'b11;
    k = 0;
    while ((link_state != 3'd2) && (k < 30)) begin
      @(negedge clk);
      k++;
    end
    chk("settle_after_glitch", 32'(k), 32'd8);
    wait_state(3'd3, 8, "to_wait_an_fail");
    pulses = 0;
    first_idx = 0;
    second_idx = 0;
    n = 0;
    while (!error && (n < 400)) begin
      @(negedge clk);
      n++;
      if (an_restart) begin
        pulses++;
        if (pulses == 1) first_idx = n;
        else second_idx = n;
      end
    end
    chk("an_pulses", 32'(pulses), 32'd2);
    chk("an_first_pulse", 32'(first_idx), 32'd100);
    chk("an_pulse_gap", 32'(second_idx - first_idx - 1), 32'd100);
    chk("failed_error", 32'(error), 32'd1);
    chk("failed_state", 32'(link_state), 32'd6);
    chk("failed_retry", 32'(retry), 32'd2);

    // Software restart out of FAILED.
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_state", 32'(link_state), 32'd1);
    chk("restart_error", 32'(error), 32'd0);
    chk("restart_retry", 32'(retry), 32'd0);
    wait_state(3'd3, 20, "to_wait_an_again");

    // Enable drop together with restart: disable wins, IDLE next cycle.
    exp_q.push_back(3'd0);
    restart = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    chk("disable_state", 32'(link_state), 32'd0);
    chk("disable_pcs_reset", 32'(pcs_reset), 32'd1);

    // Bring the link back up, then hit it with an asynchronous reset.
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd3); exp_q.push_back(3'd5);
    an = 1'b1;
    status = 16'h0001;
    enable = 1'b1;
    wait_state(3'd5, 30, "to_link_up_again");
    chk("relink_link_up", 32'(link_up), 32'd1);
    exp_q.push_back(3'd0);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    enable = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_state", 32'(link_state), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
